// File: rtl/le_word_assembler.sv
// Big-endian byte stream to little-endian word assembler.
// One output register; completing bytes reload it with no bubble.
module le_word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_data_o,
    output logic [$clog2(DATA_W/8+1)-1:0] word_bcnt_o,
    output logic              word_last_o,
    input  logic              word_ready_i
);

    localparam int BYTE_N = DATA_W / 8;
    localparam int CNT_W  = $clog2(BYTE_N + 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] merged;
    logic              accept;
    logic              complete;

    assign byte_ready_o = !word_valid_o || word_ready_i;
    assign accept       = byte_valid_i && byte_ready_o;
    assign complete     = accept &&
                          (byte_last_i || cnt == CNT_W'(BYTE_N - 1));

    // Accumulator with the current byte in lane cnt; lanes above are zero.
    always_comb begin
        merged = '0;
        for (int k = 0; k < BYTE_N; k++) begin
            if (k < int'(cnt)) begin
                merged[8*k +: 8] = acc[8*k +: 8];
            end else if (k == int'(cnt)) begin
                merged[8*k +: 8] = byte_data_i;
            end
        end
    end

    // Next fill count and accumulator.
    always_comb begin
        cnt_nxt = cnt;
        acc_nxt = acc;
        if (complete) begin
            cnt_nxt = '0;
            acc_nxt = '0;
        end else if (accept) begin
            cnt_nxt = cnt + CNT_W'(1);
            acc_nxt = merged;
        end
    end

    // Fill state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            cnt <= cnt_nxt;
            acc <= acc_nxt;
        end
    end

    // Output word register: load on completion, drop after transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
            word_bcnt_o  <= '0;
            word_last_o  <= 1'b0;
        end else if (complete) begin
            word_valid_o <= 1'b1;
            word_data_o  <= merged;
            word_bcnt_o  <= cnt + CNT_W'(1);
            word_last_o  <= byte_last_i;
        end else if (word_valid_o && word_ready_i) begin
            word_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_le_word_assembler.sv
// Directed self-checking bench for le_word_assembler (DATA_W=32).
// Inputs change 1ns after the rising edge; outputs are sampled there.
module tb_le_word_assembler;

    localparam int DATA_W = 32;

    logic        clk;
    logic        reset;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_last_i;
    logic        byte_ready_o;
    logic        word_valid_o;
    logic [31:0] word_data_o;
    logic [2:0]  word_bcnt_o;
    logic        word_last_o;
    logic        word_ready_i;

    int tests = 0;
    int fails = 0;

    le_word_assembler #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_last_i  (byte_last_i),
        .byte_ready_o (byte_ready_o),
        .word_valid_o (word_valid_o),
        .word_data_o  (word_data_o),
        .word_bcnt_o  (word_bcnt_o),
        .word_last_o  (word_last_o),
        .word_ready_i (word_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        byte_last_i  = l;
        tick();
    endtask

    task automatic idle();
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        byte_last_i  = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d,
                            input logic [2:0] n, input logic l);
        chk({tag, "_valid"}, {31'd0, word_valid_o}, 32'd1);
        chk({tag, "_data"}, word_data_o, d);
        chk({tag, "_bcnt"}, {29'd0, word_bcnt_o}, {29'd0, n});
        chk({tag, "_last"}, {31'd0, word_last_o}, {31'd0, l});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, word_valid_o}, 32'd0);
        chk({tag, "_data"}, word_data_o, 32'd0);
        chk({tag, "_bcnt"}, {29'd0, word_bcnt_o}, 32'd0);
        chk({tag, "_last"}, {31'd0, word_last_o}, 32'd0);
        chk({tag, "_brdy"}, {31'd0, byte_ready_o}, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        word_ready_i = 1'b1;
        idle();
        #3;
        chk_reset("por");
        tick();
        tick();
        reset = 1'b0;

        // Four bytes back to back form one full word.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("full_novalid", {31'd0, word_valid_o}, 32'd0);
        send(8'h44, 1'b0);
        idle();
        chk_word("full", 32'h44332211, 3'd4, 1'b0);
        tick();
        chk("full_drop", {31'd0, word_valid_o}, 32'd0);

        // Short words closed by last, second reloads with no bubble.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk_word("two", 32'h0000BBAA, 3'd2, 1'b1);
        send(8'h5C, 1'b1);
        idle();
        chk_word("one", 32'h0000005C, 3'd1, 1'b1);
        tick();
        chk("one_drop", {31'd0, word_valid_o}, 32'd0);

        // Sink stall holds the word and blocks input.
        word_ready_i = 1'b0;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hD1;
        byte_last_i  = 1'b0;
        #1;
        chk("stall_brdy0", {31'd0, byte_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_word("stall", 32'hC4C3C2C1, 3'd4, 1'b0);
            chk("stall_brdy", {31'd0, byte_ready_o}, 32'd0);
        end
        word_ready_i = 1'b1;
        #1;
        chk("stall_release_brdy", {31'd0, byte_ready_o}, 32'd1);
        tick();
        chk("stall_xfer", {31'd0, word_valid_o}, 32'd0);
        send(8'hD2, 1'b1);
        idle();
        chk_word("after_stall", 32'h0000D2D1, 3'd2, 1'b1);
        tick();

        // Eight bytes streamed at full rate.
        for (int i = 1; i <= 8; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'(i);
            byte_last_i  = 1'b0;
            #1;
            chk("stream_brdy", {31'd0, byte_ready_o}, 32'd1);
            tick();
            if (i == 4) chk_word("stream_w0", 32'h04030201, 3'd4, 1'b0);
            if (i == 8) chk_word("stream_w1", 32'h08070605, 3'd4, 1'b0);
        end
        idle();
        tick();

        // Mid-cycle reset discards an unsent word.
        word_ready_i = 1'b0;
        send(8'hE1, 1'b1);
        idle();
        chk_word("pend", 32'h000000E1, 3'd1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("rst_word");
        #1;
        reset        = 1'b0;
        word_ready_i = 1'b1;
        tick();

        // Mid-cycle reset discards a partial accumulator.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_reset("rst_part");
        #1;
        reset = 1'b0;
        tick();
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        idle();
        chk_word("post_rst", 32'hA4A3A2A1, 3'd4, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/le_word_assembler.md
LE_WORD_ASSEMBLER -- requirements
Module: le_word_assembler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the output word width in bits; it is a multiple of 8 and at least 16.
REQ-002 The block SHALL have derived localparam BYTE_N = DATA_W/8 (byte lanes per word) and CNT_W = $clog2(BYTE_N+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port byte_valid_i, input, 1 bit: the source presents a byte.
REQ-006 The block SHALL have port byte_data_i, input, 8 bits: a stream byte, in big-endian order (most significant byte first).
REQ-007 The block SHALL have port byte_last_i, input, 1 bit: marks the final byte of a message.
REQ-008 The block SHALL have port byte_ready_o, output, 1 bit: the block can accept a byte.
REQ-009 The block SHALL have port word_valid_o, output, 1 bit: the output word is valid.
REQ-010 The block SHALL have port word_data_o, output, DATA_W bits: the assembled word in little-endian lane layout.
REQ-011 The block SHALL have port word_bcnt_o, output, CNT_W bits: the number of valid bytes in word_data_o, in the range 1..BYTE_N.
REQ-012 The block SHALL have port word_last_o, output, 1 bit: the word closes a message.
REQ-013 The block SHALL have port word_ready_i, input, 1 bit: the sink accepts the word.

Function
REQ-014 The block SHALL accept a byte exactly in cycles where byte_valid_i=1 and byte_ready_o=1, and SHALL transfer a word exactly in cycles where word_valid_o=1 and word_ready_i=1.
REQ-015 The block SHALL drive byte_ready_o = !word_valid_o || word_ready_i, combinationally; no other condition stalls input.
REQ-016 The block SHALL place the k-th accepted byte of a word (k=0 first) in lane k, bits [8k+7:8k], so a big-endian byte stream becomes a little-endian word.
REQ-017 The block SHALL hold a byte-count register cnt (0..BYTE_N-1), defining states IDLE (cnt=0) and FILL (cnt>0); it SHALL have no other state.
REQ-018 On an accepted byte with cnt<BYTE_N-1 and byte_last_i=0, the block SHALL write the byte into the accumulator lane cnt and increment cnt (IDLE->FILL, or FILL->FILL).
REQ-019 The block SHALL complete a word on an accepted byte with cnt=BYTE_N-1 or byte_last_i=1.
REQ-020 On completion, at the same edge, the block SHALL load the output register with the accumulator plus the current byte, with lanes above cnt forced to 0; word_bcnt_o = cnt+1; word_last_o = byte_last_i; word_valid_o=1; cnt=0 and accumulator cleared (return to IDLE).
REQ-021 The block SHALL have a latency of 1 cycle: word_valid_o rises on the edge that accepts the completing byte.
REQ-022 When a word transfers without a completing byte accepted in the same cycle, word_valid_o SHALL fall at that edge.
REQ-023 When a word transfers and a completing byte is accepted in the same cycle, the output register SHALL reload and word_valid_o SHALL stay 1, giving no bubble.
REQ-024 While word_valid_o=1 and word_ready_i=0, word_data_o, word_bcnt_o and word_last_o SHALL be held stable.
REQ-025 The source SHALL hold byte_valid_i, byte_data_i and byte_last_i stable while byte_valid_i=1 and byte_ready_o=0; the block SHALL ignore byte_data_i and byte_last_i when byte_valid_i=0.
REQ-026 byte_last_i on the first byte of a word SHALL produce bcnt=1, with the data in lane 0 only; byte_last_i on byte BYTE_N-1 SHALL produce bcnt=BYTE_N and last=1.
REQ-027 Sustained throughput SHALL be 1 byte per cycle when word_ready_i=1.

Reset
REQ-028 While reset=1, asynchronously, the block SHALL force cnt=0, accumulator=0, word_valid_o=0, word_data_o=0, word_bcnt_o=0 and word_last_o=0.
REQ-029 While reset=1, byte_ready_o SHALL be 1, per REQ-015.
REQ-030 Reset asserted mid-word SHALL discard the partial accumulator and any unsent output word; the first byte after release SHALL go to lane 0.

Verification (DATA_W=32)
REQ-031 Reset asserted -> all outputs 0 except byte_ready_o=1; a mid-cycle assertion clears state without a clock edge.
REQ-032 Bytes 0x11,0x22,0x33,0x44 back-to-back, word_ready_i=1 -> one cycle after 0x44: word_data_o=0x44332211, bcnt=4, last=0.
REQ-033 0xAA, then 0xBB with byte_last_i=1 -> word_data_o=0x0000BBAA, bcnt=2, last=1; a single byte 0x5C with last -> 0x0000005C, bcnt=1.
REQ-034 Word valid with word_ready_i=0 for 3 cycles -> byte_ready_o=0 and word held for 3 cycles; word_ready_i=1 -> transfer, then byte_ready_o=1.
REQ-035 8 consecutive bytes 0x01..0x08 with word_ready_i=1 -> 0x04030201 then 0x08070605 with no bubble, byte_ready_o constantly 1.
REQ-036 Reset after bytes 0x01,0x02, then 0xA1..0xA4 -> word 0xA4A3A2A1, bcnt=4; no residue of 0x01/0x02.
